dm_selftest: RTL and testbench
==============================

# dm_selftest

Parametrised data-memory block with a built-in pattern sweep engine. It replaces the fixed four-value write-data test harness around the data memory. It owns a word-addressed synchronous RAM and offers a manual port (single write/read driven from board switches) plus a self-test FSM that fills every word with a selectable pattern, reads it back and counts mismatches. `rd_data` feeds the existing 7-segment LED driver.

## Interface
- `ADDR_W`, 6: word-address width; depth D = 2^ADDR_W (6 matches DM_Addr[7:2]).
- `DATA_W`, 32: word width, ≥ 8.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; sampled only in IDLE or DONE; high launches a sweep.
- `mode`  in  2  pattern select, sampled together with `start`.
- `seed`  in  DATA_W  pattern seed, sampled together with `start`.
- `man_we`  in  1  manual write enable; honoured only in IDLE/DONE.
- `man_addr`  in  ADDR_W  manual word address.
- `man_data`  in  DATA_W  manual write data.
- `busy`  out  1  high in FILL and READ.
- `done`  out  1  high in DONE.
- `pass`  out  1  high in DONE when `err_cnt`=0.
- `err_cnt`  out  ADDR_W+1  mismatch count of the current or last sweep.
- `first_err_addr`  out  ADDR_W  lowest mismatching address; 0 if there is none.
- `rd_data`  out  DATA_W  registered read data.

## Operation
- States: IDLE → FILL → READ → DONE. In DONE, `start`=1 re-enters FILL. There is no other exit except reset.
- Launch from IDLE or DONE: clears `err_cnt`, `first_err_addr` and the address counter, and latches `mode` and `seed`.
- Pattern P(a), with all arithmetic mod 2^DATA_W and a zero-extended:
  - 00: seed.
  - 01: seed + a.
  - 10: ~(seed + a).
  - 11: seed rotated left by (a mod DATA_W).
- FILL:
  - Writes P(a) to address a for a = 0..D-1, one word per cycle.
  - Wraps the counter to 0 and enters READ.
- READ:
  - Issues reads for a = 0..D-1.
  - Each returned word is compared with P(a).
  - On a mismatch, `err_cnt` increments and `first_err_addr` is captured if this is the first mismatch.
  - `err_cnt` cannot overflow (max D).
- DONE: holds all results.
- Manual port:
  - `man_we` writes `man_data` to `man_addr` in IDLE/DONE.
  - In IDLE/DONE, `rd_data` = mem[`man_addr`], registered.
  - During a sweep, `man_we` is ignored, and `rd_data` shows the sweep read data.
- A start/write collision in the same cycle in IDLE/DONE: the write is performed; the sweep then overwrites that word.

## Timing
- Reset values: state IDLE; `busy`, `done`, `pass`, `err_cnt`, `first_err_addr`, `rd_data` all 0.
  - Memory contents are not reset and are retained across `rst_n`.
- Reset asserted mid-sweep: aborts immediately (asynchronous). Words already written keep their new values.
- RAM: write on the clock edge; read latency is 1 cycle (address at edge n, `rd_data` valid after edge n+1).
- `start` sampled at edge E0:
  - `busy` rises at E0.
  - Last FILL write occurs at E0+D.
  - Final compare is registered at E0+2D+1.
  - `done` and `pass` rise and `busy` falls at E0+2D+2.
  - `err_cnt` is final when `done` rises.
- `start` held high in DONE: a new sweep starts at the next edge, so `done` is a one-cycle pulse.
- `start` while busy: ignored.

## Configuration
- `DM_FAULT_INJECT_EN` defined: during FILL, address 0 is written with P(0) XOR 1. Every sweep therefore reports `err_cnt` ≥ 1 and `first_err_addr`=0, which exercises the checker.
- `DM_FAULT_INJECT_EN` not defined: FILL writes exact patterns. No extra logic is compiled in.

## Test plan
- Reset: drive `rst_n`=0 and check all outputs are 0 and the state is IDLE. Release reset, then manual write 0x12345678 to addr 3 and read it → `rd_data`=0x12345678 one cycle later.
- Default params, `mode`=01, `seed`=0, start → `busy` for 130 cycles, then `done`=1, `pass`=1, `err_cnt`=0. Manual read addr 5 → 0x00000005.
- `mode`=11, `seed`=1 → `pass`=1. Addr 33 holds 0x00000002; addr 31 holds 0x80000000.
- `start` and `man_we` pulsed mid-FILL → no restart, manual write not performed, `pass`=1 at cycle E0+130.
- `rst_n` low at E0+70 (during READ) → outputs 0 immediately. A restart with `mode`=10, `seed`=0 → `pass`=1, addr 0 holds 0xFFFFFFFF.
- `DM_FAULT_INJECT_EN` defined, `mode`=00, `seed`=0xA5A5A5A5 → `pass`=0, `err_cnt`=1, `first_err_addr`=0, manual read addr 0 = 0xA5A5A5A4.

Source files
------------

// File: rtl/dm_selftest.sv
// dm_selftest: word-addressed synchronous data memory with a manual port and
// a self-test sweep engine (fill every word with a pattern, read back, count
// mismatches). rd_data drives the 7-segment display path.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, mode, seed   sweep launch (sampled in IDLE/DONE only)
//   man_we/addr/data    manual write port, honoured in IDLE/DONE only
//   busy, done, pass    sweep status (registered)
//   err_cnt             mismatch count of the current or last sweep
//   first_err_addr      lowest mismatching address (0 if none)
//   rd_data             registered read data (manual or sweep read)
//
// Optional feature: define DM_FAULT_INJECT_EN to corrupt bit 0 of the word
// written to address 0 during FILL, so every sweep must report a mismatch.
module dm_selftest #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              man_we,
  input  logic [ADDR_W-1:0] man_addr,
  input  logic [DATA_W-1:0] man_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_READ = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic              cmp_vld_q, cmp_vld_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] fea_q, fea_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [DATA_W-1:0] pat_fill_c;
  logic [DATA_W-1:0] pat_cmp_c;

  // Pattern P(a) for the latched mode/seed.
  function automatic logic [DATA_W-1:0] pattern(
    input logic [1:0]        m,
    input logic [DATA_W-1:0] s,
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0]   sum;
    logic [2*DATA_W-1:0] dbl;
    int unsigned         sh;
    sum = s + DATA_W'(a);
    sh  = 32'(a) % DATA_W;
    // Rotate by shifting a doubled copy; the upper half is the rotated word.
    dbl = {s, s} << sh;
    case (m)
      2'b00:   pattern = s;
      2'b01:   pattern = sum;
      2'b10:   pattern = ~sum;
      default: pattern = dbl[2*DATA_W-1:DATA_W];
    endcase
  endfunction

  assign pat_fill_c = pattern(mode_q, seed_q, cnt_q[ADDR_W-1:0]);
  assign pat_cmp_c  = pattern(mode_q, seed_q, cmp_addr_q);

  // Next-state, datapath and memory-port control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    seed_d      = seed_q;
    cmp_vld_d   = 1'b0;
    cmp_addr_d  = cmp_addr_q;
    err_cnt_d   = err_cnt_q;
    fea_d       = fea_q;
    rd_data_d   = rd_data_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = man_addr;
    mem_wdata_c = man_data;

    // Compare stage: one cycle behind each sweep read issue.
    if (cmp_vld_q && (rd_data_q != pat_cmp_c)) begin
      if (err_cnt_q == '0) begin
        fea_d = cmp_addr_q;
      end
      if (err_cnt_q != CNT_W'(DEPTH)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        mem_we_c  = man_we;
        rd_data_d = mem_q[man_addr];
        if (start) begin
          state_d   = S_FILL;
          cnt_d     = '0;
          mode_d    = mode;
          seed_d    = seed;
          err_cnt_d = '0;
          fea_d     = '0;
        end
      end
      S_FILL: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = cnt_q[ADDR_W-1:0];
`ifdef DM_FAULT_INJECT_EN
        mem_wdata_c = pat_fill_c ^ DATA_W'(cnt_q == '0);
`else
        mem_wdata_c = pat_fill_c;
`endif
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_READ: begin
        if (cnt_q < CNT_W'(DEPTH)) begin
          rd_data_d  = mem_q[cnt_q[ADDR_W-1:0]];
          cmp_vld_d  = 1'b1;
          cmp_addr_d = cnt_q[ADDR_W-1:0];
          cnt_d      = cnt_q + CNT_W'(1);
        end else if (!cmp_vld_q) begin
          // Last compare has been registered; results are final.
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_FILL) || (state_d == S_READ);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_cnt_d == '0);
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mode_q     <= '0;
      seed_q     <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
      fea_q      <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      seed_q     <= seed_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_addr_q <= cmp_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      fea_q      <= fea_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // RAM array: contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = fea_q;
  assign rd_data        = rd_data_q;

endmodule

// File: tb/tb_dm_selftest.sv
// Testbench for dm_selftest (default parameters).
module tb_dm_selftest;

  localparam int DEPTH = 64;
`ifdef DM_FAULT_INJECT_EN
  localparam bit FAULT = 1'b1;
`else
  localparam bit FAULT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] seed = '0;
  logic        man_we = 1'b0;
  logic [5:0]  man_addr = '0;
  logic [31:0] man_data = '0;
  logic        busy, done, pass;
  logic [6:0]  err_cnt;
  logic [5:0]  first_err_addr;
  logic [31:0] rd_data;

  dm_selftest dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .seed(seed),
    .man_we(man_we), .man_addr(man_addr), .man_data(man_data),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int   busy_cycles;
    logic pass;
    int   err;
    int   fea;
  } sweep_exp_t;

  sweep_exp_t  sb_sweep[$];
  logic [31:0] sb_rd[$];
  logic [31:0] model_mem [DEPTH];

  // Reference pattern, rotation done one bit at a time.
  function automatic logic [31:0] ref_pat(input logic [1:0] m, input logic [31:0] s, input int a);
    logic [31:0] r;
    case (m)
      2'b00: r = s;
      2'b01: r = s + 32'(a);
      2'b10: r = ~(s + 32'(a));
      default: begin
        r = s;
        for (int i = 0; i < (a % 32); i++) r = {r[30:0], r[31]};
      end
    endcase
    return r;
  endfunction

  task automatic do_write(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    man_we = 1'b1; man_addr = a; man_data = d;
    @(negedge clk);
    man_we = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic do_read(input string name, input logic [5:0] a);
    logic [31:0] exp;
    @(negedge clk);
    man_addr = a;
    sb_rd.push_back(model_mem[a]);
    @(negedge clk);
    exp = sb_rd.pop_front();
    total++;
    if (rd_data !== exp) begin
      bad++;
      $display("FAIL %s: rd_data got %h want %h", name, rd_data, exp);
    end
  endtask

  // Runs one sweep. poke_at: cycle to pulse start+man_we (mid-sweep);
  // abort_at: cycle to assert reset. -1 disables either.
  task automatic run_sweep(input string name, input logic [1:0] m, input logic [31:0] s,
                           input int poke_at, input int abort_at);
    sweep_exp_t e;
    int         busy_n;
    int         k;
    logic [31:0] exp_rd;
    @(negedge clk);
    start = 1'b1; mode = m; seed = s;
    for (int a = 0; a < DEPTH; a++) begin
      model_mem[a] = ref_pat(m, s, a);
      if (FAULT && a == 0) model_mem[a] = model_mem[a] ^ 32'h1;
    end
    e.busy_cycles = 2 * DEPTH + 2;
    e.pass = !FAULT;
    e.err  = FAULT ? 1 : 0;
    e.fea  = 0;
    sb_sweep.push_back(e);
    @(negedge clk);
    start = 1'b0; mode = 2'b00; seed = '0;
    busy_n = 0;
    for (k = 0; k < 1000; k++) begin
      if (k == 0) begin
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          bad++;
          $display("FAIL %s launch: busy/done got %b%b want 10", name, busy, done);
        end
      end
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        void'(sb_sweep.pop_front());
        total++;
        if ({busy, done, pass, err_cnt, first_err_addr, rd_data} !== '0) begin
          bad++;
          $display("FAIL %s abort: outputs got %b%b%b %h %h %h want all 0",
                   name, busy, done, pass, err_cnt, first_err_addr, rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (done) break;
      if (busy) busy_n++;
      if (k == DEPTH + 1 || k == 2 * DEPTH) begin
        exp_rd = model_mem[k - DEPTH - 1];
        total++;
        if (rd_data !== exp_rd) begin
          bad++;
          $display("FAIL %s sweep_rd k=%0d: got %h want %h", name, k, rd_data, exp_rd);
        end
      end
      if (k == poke_at) begin
        start = 1'b1; man_we = 1'b1; man_addr = 6'd5; man_data = 32'hDEADBEEF;
      end else if (k == poke_at + 1) begin
        start = 1'b0; man_we = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; man_we = 1'b0;
    e = sb_sweep.pop_front();
    total++;
    if (k >= 1000) begin
      bad++;
      $display("FAIL %s timeout: done never rose within %0d cycles", name, k);
      return;
    end
    if (busy_n != e.busy_cycles || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s busy: got %0d cycles (busy=%b) want %0d", name, busy_n, busy, e.busy_cycles);
    end
    total++;
    if (pass !== e.pass) begin
      bad++;
      $display("FAIL %s pass: got %b want %b", name, pass, e.pass);
    end
    total++;
    if (err_cnt !== 7'(e.err)) begin
      bad++;
      $display("FAIL %s err_cnt: got %0d want %0d", name, err_cnt, e.err);
    end
    total++;
    if (first_err_addr !== 6'(e.fea)) begin
      bad++;
      $display("FAIL %s first_err_addr: got %0d want %0d", name, first_err_addr, e.fea);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, pass} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 000", {busy, done, pass});
    end
    total++;
    if (err_cnt !== '0 || first_err_addr !== '0 || rd_data !== '0) begin
      bad++;
      $display("FAIL reset_data: got %h %h %h want 0 0 0", err_cnt, first_err_addr, rd_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_write(6'd3, 32'h12345678);
    do_read("manual_rw", 6'd3);
  endtask

  task automatic test_sweep_mode01();
    run_sweep("m01_s0", 2'b01, 32'h0, -1, -1);
    do_read("m01_addr5", 6'd5);
  endtask

  task automatic test_sweep_rotate();
    run_sweep("m11_s1", 2'b11, 32'h1, -1, -1);
    do_read("m11_addr33", 6'd33);
    do_read("m11_addr31", 6'd31);
  endtask

  task automatic test_poke_mid_fill();
    run_sweep("poke", 2'b01, 32'h100, 10, -1);
    do_read("poke_addr5", 6'd5);
  endtask

  task automatic test_abort_and_restart();
    run_sweep("abort", 2'b01, 32'h7, -1, 70);
    run_sweep("m10_s0", 2'b10, 32'h0, -1, -1);
    do_read("m10_addr0", 6'd0);
  endtask

  task automatic test_const_pattern();
    run_sweep("m00_a5", 2'b00, 32'hA5A5A5A5, -1, -1);
    do_read("m00_addr0", 6'd0);
  endtask

  // Launch straight out of DONE with start held: done must drop next cycle.
  task automatic test_back_to_back();
    run_sweep("b2b_1", 2'b01, 32'h55, -1, -1);
    run_sweep("b2b_2", 2'b10, 32'h1234, -1, -1);
    do_read("b2b_addr63", 6'd63);
  endtask

  initial begin
    test_reset();
    test_sweep_mode01();
    test_sweep_rotate();
    test_poke_mid_fill();
    test_abort_and_restart();
    test_const_pattern();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
